// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment constants, types and digit helpers
package seg7_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 7;
    localparam int FRAME_W    = NUM_DIGITS * DIGIT_W;

    typedef logic [1:0]         digit_sel_t;
    typedef logic [DIGIT_W-1:0] seg_t;
    typedef logic [FRAME_W-1:0] frame_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam seg_t SEG_ZERO  = 7'b1000000;
    localparam seg_t SEG_ONE   = 7'b1111001;
    localparam seg_t SEG_TWO   = 7'b0100100;
    localparam seg_t SEG_THREE = 7'b0110000;
    localparam seg_t SEG_FOUR  = 7'b0011001;
    localparam seg_t SEG_FIVE  = 7'b0010010;
    localparam seg_t SEG_SIX   = 7'b0000010;
    localparam seg_t SEG_SEVEN = 7'b1111000;
    localparam seg_t SEG_EIGHT = 7'b0000000;
    localparam seg_t SEG_NINE  = 7'b0010000;
    localparam seg_t SEG_BLANK = 7'h7F;

    function automatic seg_t digit_pattern(frame_t w, digit_sel_t d);
        return w[int'(d)*DIGIT_W +: DIGIT_W];
    endfunction

    function automatic logic [NUM_DIGITS-1:0] anode_of(digit_sel_t d);
        return ~(NUM_DIGITS'(1) << d);
    endfunction

    // Digit d is a leading zero when it and every higher digit show SEG_ZERO; digit 0 never is
    function automatic logic leading_zero(frame_t w, digit_sel_t d);
        logic z;
        z = d != '0;
        for (int k = 0; k < NUM_DIGITS; k++)
            if (k >= int'(d) && w[k*DIGIT_W +: DIGIT_W] != SEG_ZERO) z = 1'b0;
        return z;
    endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: frame input and display output bundle (blink only with SEG7_BLINK_EN)
interface seg7_scan_driver_if;
    import seg7_pkg::*;
    frame_t                  display_all;
    logic                    enable;
    logic [NUM_DIGITS-1:0]   an;
    seg_t                    seg;
    logic                    dp;
    logic                    frame_done;
`ifdef SEG7_BLINK_EN
    logic                    blink;
    modport master (output display_all, enable, blink, input an, seg, dp, frame_done);
    modport slave  (input display_all, enable, blink, output an, seg, dp, frame_done);
`else
    modport master (output display_all, enable, input an, seg, dp, frame_done);
    modport slave  (input display_all, enable, output an, seg, dp, frame_done);
`endif
endinterface

// File: rtl/seg7_refresh_prescaler.sv
// seg7_refresh_prescaler: free-running 0..DIV-1 counter, o_tick high in the last count
module seg7_refresh_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_count;

    assign o_tick = r_count == W'(DIV - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_count <= '0;
        else        r_count <= o_tick ? '0 : r_count + W'(1);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-seg driver with tear-free latch and zero blanking; SEG7_BLINK_EN adds blink
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
`ifdef SEG7_BLINK_EN
   ,parameter int BLINK_FRAMES  = 250
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_driver_if.slave   bus
);
    logic                  w_tick;
    logic                  w_wrap;
    logic                  w_en;
    logic                  w_blank;
    digit_sel_t            w_sel_nxt;
    frame_t                w_shadow_nxt;
    seg_t                  w_pat;
    digit_sel_t            r_sel;
    frame_t                r_shadow;
    logic [NUM_DIGITS-1:0] r_an;
    seg_t                  r_seg;
    logic                  r_fd;

    seg7_refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    // The digit-0 slot of a new frame must already show the freshly captured word
    always_comb begin
        w_wrap       = w_tick && r_sel == digit_sel_t'(NUM_DIGITS - 1);
        w_sel_nxt    = r_sel + 2'd1;
        w_shadow_nxt = w_wrap ? bus.display_all : r_shadow;
        w_pat        = digit_pattern(w_shadow_nxt, w_sel_nxt);
        w_blank      = BLANK_LEADING && leading_zero(w_shadow_nxt, w_sel_nxt);
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_dark;
    logic          w_blink_last;

    assign w_blink_last = r_blink_cnt == BW'(BLINK_FRAMES - 1);
    assign w_en         = bus.enable && !r_dark;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_dark      <= 1'b0;
        end else if (!bus.blink) begin
            r_blink_cnt <= '0;
            r_dark      <= 1'b0;
        end else if (w_wrap) begin
            r_blink_cnt <= w_blink_last ? '0 : r_blink_cnt + BW'(1);
            r_dark      <= r_dark ^ w_blink_last;
        end
`else
    assign w_en = bus.enable;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_sel    <= digit_sel_t'(NUM_DIGITS - 1);
            r_shadow <= '1;
            r_an     <= '1;
            r_seg    <= SEG_BLANK;
            r_fd     <= 1'b0;
        end else begin
            r_fd <= w_wrap;
            if (w_tick) begin
                r_sel    <= w_sel_nxt;
                r_shadow <= w_shadow_nxt;
            end
            if (!w_en) begin
                r_an  <= '1;
                r_seg <= SEG_BLANK;
            end else if (w_tick) begin
                r_an  <= w_blank ? '1 : anode_of(w_sel_nxt);
                r_seg <= w_blank ? SEG_BLANK : w_pat;
            end
        end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = 1'b1;
    assign bus.frame_done = r_fd;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: table vectors, directed corner sequences and random stimulus vs a cycle-count model
module tb_seg7_scan_driver;
    import seg7_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   enable;
    frame_t display_all;
    int     checks = 0;
    int     errors = 0;
    bit     mon_on = 1'b0;

    always #5 clk = ~clk;

    seg7_scan_driver_if bus0 ();
    seg7_scan_driver_if bus1 ();

    assign bus0.display_all = display_all;
    assign bus0.enable      = enable;
    assign bus1.display_all = display_all;
    assign bus1.enable      = enable;
`ifdef SEG7_BLINK_EN
    assign bus0.blink = 1'b0;
    assign bus1.blink = 1'b0;
`endif

    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    seg7_scan_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: edge e after reset is a tick when e%4==0; tick k shows digit (k-1)%4
    function automatic logic [10:0] view(frame_t w, int d, bit blank);
        logic [3:0] a;
        bit         z;
        z = blank && d > 0;
        for (int j = d; j < 4; j++)
            if (w[j*7 +: 7] != SEG_ZERO) z = 1'b0;
        a = 4'b0001 << d;
        return z ? {4'hF, SEG_BLANK} : {~a, w[d*7 +: 7]};
    endfunction

    int         m_edges;
    int         m_dig;
    bit         m_tick;
    frame_t     m_shadow;
    logic [3:0] m_an [2];
    seg_t       m_seg [2];
    logic       m_fd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges  = 0;
            m_shadow = '1;
            m_fd     = 1'b0;
            for (int b = 0; b < 2; b++) begin
                m_an[b]  = 4'hF;
                m_seg[b] = SEG_BLANK;
            end
        end else begin
            m_edges++;
            m_tick = (m_edges % 4) == 0;
            m_dig  = (m_edges / 4 + 3) % 4;
            m_fd   = m_tick && m_dig == 0;
            if (m_fd) m_shadow = display_all;
            for (int b = 0; b < 2; b++)
                if (!enable) begin
                    m_an[b]  = 4'hF;
                    m_seg[b] = SEG_BLANK;
                end else if (m_tick) begin
                    {m_an[b], m_seg[b]} = view(m_shadow, m_dig, b == 1);
                end
        end
    end

    always @(negedge clk) if (mon_on) begin
        chk("mon_an0",  bus0.an,         m_an[0]);
        chk("mon_seg0", bus0.seg,        m_seg[0]);
        chk("mon_fd0",  bus0.frame_done, m_fd);
        chk("mon_dp0",  bus0.dp,         1'b1);
        chk("mon_an1",  bus1.an,         m_an[1]);
        chk("mon_seg1", bus1.seg,        m_seg[1]);
        chk("mon_fd1",  bus1.frame_done, m_fd);
        chk("mon_dp1",  bus1.dp,         1'b1);
    end

    task automatic wait_fd();
        int n;
        n = 0;
        @(negedge clk);
        do begin
            @(negedge clk);
            n++;
        end while (bus1.frame_done !== 1'b1 && n < 40);
        chk("wait_frame_done", bus1.frame_done, 1'b1);
    endtask

    typedef struct {
        frame_t          disp;
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
    } vec_t;

    vec_t       tbl [6];
    logic [3:0] s2_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seg_t       s2_seg [4] = '{SEG_FOUR, SEG_THREE, SEG_TWO, SEG_ONE};
    seg_t       codes  [10] = '{SEG_ZERO, SEG_ONE, SEG_TWO, SEG_THREE, SEG_FOUR,
                                SEG_FIVE, SEG_SIX, SEG_SEVEN, SEG_EIGHT, SEG_NINE};

    function automatic frame_t rand_word();
        frame_t w;
        int     r;
        for (int k = 0; k < 4; k++) begin
            r = $urandom_range(0, 15);
            w[k*7 +: 7] = (r < 6) ? SEG_ZERO : (r < 15) ? codes[$urandom_range(1, 9)] : 7'($urandom);
        end
        return w;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{{SEG_ONE, SEG_TWO, SEG_THREE, SEG_FOUR},
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {SEG_ONE, SEG_TWO, SEG_THREE, SEG_FOUR}};
        tbl[1] = '{{SEG_ZERO, SEG_ZERO, SEG_FIVE, SEG_ZERO},
                   {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {SEG_BLANK, SEG_BLANK, SEG_FIVE, SEG_ZERO}};
        tbl[2] = '{{SEG_ZERO, SEG_ZERO, SEG_ZERO, SEG_ZERO},
                   {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_ZERO}};
        tbl[3] = '{{SEG_ZERO, SEG_SEVEN, SEG_ZERO, SEG_ZERO},
                   {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {SEG_BLANK, SEG_SEVEN, SEG_ZERO, SEG_ZERO}};
        tbl[4] = '{{SEG_ZERO, 7'h55, SEG_ZERO, SEG_ONE},
                   {4'b1111, 4'b1011, 4'b1101, 4'b1110}, {SEG_BLANK, 7'h55, SEG_ZERO, SEG_ONE}};
        tbl[5] = '{{SEG_EIGHT, SEG_ZERO, SEG_ZERO, SEG_ZERO},
                   {4'b0111, 4'b1011, 4'b1101, 4'b1110}, {SEG_EIGHT, SEG_ZERO, SEG_ZERO, SEG_ZERO}};

        rst_n       = 1'b1;
        enable      = 1'b1;
        display_all = {SEG_ONE, SEG_TWO, SEG_THREE, SEG_FOUR};
        #1 rst_n = 1'b0;
        mon_on = 1'b1;
        #1;
        chk("rst_an",  bus0.an,         4'hF);
        chk("rst_seg", bus0.seg,        SEG_BLANK);
        chk("rst_dp",  bus0.dp,         1'b1);
        chk("rst_fd",  bus0.frame_done, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("first_dark_an", bus0.an, 4'hF);
            chk("first_dark_fd", bus0.frame_done, 1'b0);
        end
        @(negedge clk);
        chk("first_tick_an", bus0.an, 4'b1110);
        chk("first_tick_fd", bus0.frame_done, 1'b1);

        for (int s = 0; s < 8; s++)
            for (int c = 0; c < 4; c++) begin
                chk("scan_an",  bus0.an,  s2_an[s % 4]);
                chk("scan_seg", bus0.seg, s2_seg[s % 4]);
                @(negedge clk);
            end

        for (int i = 0; i < 6; i++) begin
            display_all = tbl[i].disp;
            wait_fd();
            for (int d = 0; d < 4; d++) begin
                chk("tbl_an",  bus1.an,  tbl[i].an[d]);
                chk("tbl_seg", bus1.seg, tbl[i].seg[d]);
                if (d < 3) repeat (4) @(negedge clk);
            end
        end

        display_all = {4{SEG_ONE}};
        wait_fd();
        repeat (9) @(negedge clk);
        display_all = {4{SEG_NINE}};
        repeat (3) @(negedge clk);
        chk("tear_old_an",  bus0.an,  4'b0111);
        chk("tear_old_seg", bus0.seg, SEG_ONE);
        repeat (4) @(negedge clk);
        chk("tear_new_fd",  bus0.frame_done, 1'b1);
        chk("tear_new_an",  bus0.an,  4'b1110);
        chk("tear_new_seg", bus0.seg, SEG_NINE);

        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("en_off_an",  bus0.an,  4'hF);
        chk("en_off_seg", bus0.seg, SEG_BLANK);
        repeat (4) @(negedge clk);
        chk("en_still_off", bus0.an, 4'hF);
        enable = 1'b1;
        @(negedge clk);
        chk("en_wait_tick", bus0.an, 4'hF);
        @(negedge clk);
        chk("en_resume_an",  bus0.an,  4'b0111);
        chk("en_resume_seg", bus0.seg, SEG_NINE);
        chk("en_resume_fd",  bus0.frame_done, 1'b0);
        repeat (4) @(negedge clk);
        chk("en_fd_timing", bus0.frame_done, 1'b1);
        chk("en_fd_an",     bus0.an, 4'b1110);

        repeat (9) @(negedge clk);
        chk("pre_areset_an", bus0.an, 4'b1011);
        #2 rst_n = 1'b0;
        #1;
        chk("areset_an0",  bus0.an,  4'hF);
        chk("areset_seg0", bus0.seg, SEG_BLANK);
        chk("areset_an1",  bus1.an,  4'hF);
        chk("areset_fd",   bus0.frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_areset_dark", bus0.an, 4'hF);
        @(negedge clk);
        chk("post_areset_an",  bus0.an,  4'b1110);
        chk("post_areset_seg", bus0.seg, SEG_NINE);
        chk("post_areset_fd",  bus0.frame_done, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) display_all = rand_word();
            if ($urandom_range(0, 29) == 0) enable = ~enable;
            if (i == 700) begin
                #3 rst_n = 1'b0;
                #1 chk("rand_areset_an", bus1.an, 4'hF);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        mon_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
